// File: rtl/stage_sched.sv
// ============================================================================
// Module   : stage_sched
// Brief    : Layer sequencer feeding tokens and per-head biases into the
//            4-head attention stage, with per-layer drain and timeout.
// Revision : 1.0
// ============================================================================
`default_nettype none

module stage_sched #(
    parameter  int ATT_WIDTH = 16,
    parameter  int N_TOKEN   = 16,
    parameter  int N_LAYER   = 4,
    parameter  int DRAIN_MAX = 1024,
    localparam int c_lw      = $clog2(N_LAYER) + 1,
    localparam int c_aw      = $clog2(N_LAYER * N_TOKEN),
    localparam int c_tw      = $clog2(N_TOKEN + 1),
    localparam int c_dw      = $clog2(DRAIN_MAX)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [c_lw-1:0]      cfg_layers,
    output logic                 busy,
    output logic                 done,
    output logic                 err_timeout,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [ATT_WIDTH-1:0] in_data,
    output logic [c_aw-1:0]      bias_addr,
    input  logic [ATT_WIDTH-1:0] bias_rdata_1,
    input  logic [ATT_WIDTH-1:0] bias_rdata_2,
    input  logic [ATT_WIDTH-1:0] bias_rdata_3,
    input  logic [ATT_WIDTH-1:0] bias_rdata_4,
    output logic                 stg_en,
    output logic [ATT_WIDTH-1:0] stg_data,
    output logic [ATT_WIDTH-1:0] stg_bias_1,
    output logic [ATT_WIDTH-1:0] stg_bias_2,
    output logic [ATT_WIDTH-1:0] stg_bias_3,
    output logic [ATT_WIDTH-1:0] stg_bias_4,
    input  logic                 stg_end
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FEED  = 3'd1,
        S_DRAIN = 3'd2,
        S_NEXT  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam logic [c_tw-1:0] c_tok_max    = c_tw'(N_TOKEN);
    localparam logic [c_dw-1:0] c_drain_last = c_dw'(DRAIN_MAX - 1);
    localparam logic [c_lw-1:0] c_layer_max  = c_lw'(N_LAYER);

    state_t               r_state;
    state_t               w_next;
    logic [c_lw-1:0]      r_layers;
    logic [c_lw-1:0]      r_layer_cnt;
    logic [c_lw-1:0]      w_cfg;
    logic [c_tw-1:0]      r_tok_cnt;
    logic [c_dw-1:0]      r_drain_cnt;
    logic                 r_err;
    logic                 r_hs;
    logic                 r_stg_en;
    logic [ATT_WIDTH-1:0] r_data;
    logic                 w_hs;
    logic                 w_timeout;
    logic                 w_last_layer;

    always_comb begin
        w_cfg = cfg_layers;
        if (cfg_layers == '0) begin
            w_cfg = c_lw'(1);
        end else if (cfg_layers > c_layer_max) begin
            w_cfg = c_layer_max;
        end
    end

    assign in_ready     = (r_state == S_FEED) && (r_tok_cnt < c_tok_max);
    assign w_hs         = in_valid && in_ready;
    assign w_last_layer = ((r_layer_cnt + c_lw'(1)) == r_layers);
    assign w_timeout    = (r_state == S_DRAIN) && !stg_end && (r_drain_cnt == c_drain_last);
    assign bias_addr    = (r_state == S_FEED)
                        ? c_aw'(32'(r_layer_cnt) * N_TOKEN + 32'(r_tok_cnt)) : '0;

    assign busy        = (r_state != S_IDLE);
    assign done        = (r_state == S_DONE);
    assign err_timeout = r_err;
    assign stg_en      = r_stg_en;
    assign stg_data    = r_data;
    // Bias SRAM answers one cycle after the address, aligned with the registered token.
    assign stg_bias_1  = r_hs ? bias_rdata_1 : '0;
    assign stg_bias_2  = r_hs ? bias_rdata_2 : '0;
    assign stg_bias_3  = r_hs ? bias_rdata_3 : '0;
    assign stg_bias_4  = r_hs ? bias_rdata_4 : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next = S_FEED;
            // Stay one extra cycle after the last token so its bias pair is presented.
            S_FEED:  if (r_tok_cnt == c_tok_max) w_next = S_DRAIN;
            S_DRAIN: begin
                if (stg_end) begin
                    w_next = S_NEXT;
                end else if (w_timeout) begin
                    w_next = S_DONE;
                end
            end
            S_NEXT:  w_next = w_last_layer ? S_DONE : S_FEED;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_layers    <= '0;
            r_layer_cnt <= '0;
            r_tok_cnt   <= '0;
            r_drain_cnt <= '0;
            r_err       <= 1'b0;
            r_hs        <= 1'b0;
            r_stg_en    <= 1'b0;
            r_data      <= '0;
        end else begin
            r_stg_en <= (w_next == S_FEED) || (w_next == S_DRAIN);
            r_hs     <= w_hs;
            r_data   <= w_hs ? in_data : '0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_layers    <= w_cfg;
                        r_err       <= 1'b0;
                        r_layer_cnt <= '0;
                        r_tok_cnt   <= '0;
                        r_drain_cnt <= '0;
                    end
                end
                S_FEED: begin
                    if (w_hs) r_tok_cnt <= r_tok_cnt + c_tw'(1);
                end
                S_DRAIN: begin
                    if (w_timeout) begin
                        r_err <= 1'b1;
                    end else if (!stg_end && (r_drain_cnt != c_drain_last)) begin
                        r_drain_cnt <= r_drain_cnt + c_dw'(1);
                    end
                end
                S_NEXT: begin
                    r_layer_cnt <= r_layer_cnt + c_lw'(1);
                    r_tok_cnt   <= '0;
                    r_drain_cnt <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_stage_sched.sv
// ============================================================================
// Module   : tb_stage_sched
// Brief    : Directed scoreboard bench for stage_sched.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_stage_sched;

    localparam int W  = 16;
    localparam int NT = 16;
    localparam int DM = 1024;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic [2:0]    cfg_layers = '0;
    logic          busy, done, err_timeout;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  in_data = '0;
    logic [5:0]    bias_addr;
    logic [W-1:0]  bias_rdata_1 = '0, bias_rdata_2 = '0, bias_rdata_3 = '0, bias_rdata_4 = '0;
    logic          stg_en;
    logic [W-1:0]  stg_data, stg_bias_1, stg_bias_2, stg_bias_3, stg_bias_4;
    logic          stg_end = 1'b0;

    always #5 clk = ~clk;

    stage_sched dut (
        .clk(clk), .rst(rst), .start(start), .cfg_layers(cfg_layers),
        .busy(busy), .done(done), .err_timeout(err_timeout),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .bias_addr(bias_addr),
        .bias_rdata_1(bias_rdata_1), .bias_rdata_2(bias_rdata_2),
        .bias_rdata_3(bias_rdata_3), .bias_rdata_4(bias_rdata_4),
        .stg_en(stg_en), .stg_data(stg_data),
        .stg_bias_1(stg_bias_1), .stg_bias_2(stg_bias_2),
        .stg_bias_3(stg_bias_3), .stg_bias_4(stg_bias_4),
        .stg_end(stg_end)
    );

    // Bias buffer: address+4, heads offset by 0x1000 so swapped heads show up.
    function automatic logic [W-1:0] bias_of(input int a, input int k);
        return W'(a + 4 + (k - 1) * 4096);
    endfunction

    always_ff @(posedge clk) begin
        bias_rdata_1 <= bias_of(int'(bias_addr), 1);
        bias_rdata_2 <= bias_of(int'(bias_addr), 2);
        bias_rdata_3 <= bias_of(int'(bias_addr), 3);
        bias_rdata_4 <= bias_of(int'(bias_addr), 4);
    end

    int          n_cmp = 0;
    int          n_err = 0;
    bit          mon_en = 1'b0;
    bit          pend = 1'b0;
    logic [79:0] q[$];
    int          exp_tok = 0, exp_layer = 0;
    int          cnt_done = 0, cnt_gap = 0, cnt_fwd = 0;

    task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic monitor();
        logic [79:0] got, e;
        int a;
        forever begin
            @(negedge clk);
            if (!mon_en) begin
                q.delete();
                pend = 1'b0;
                exp_tok = 0; exp_layer = 0;
                cnt_done = 0; cnt_gap = 0; cnt_fwd = 0;
            end else begin
                got = {stg_data, stg_bias_1, stg_bias_2, stg_bias_3, stg_bias_4};
                if (pend) begin
                    e = q.pop_front();
                    chk("stage_out", got, e);
                    cnt_fwd++;
                end else begin
                    chk("stage_idle", got, 80'(0));
                end
                if (done) cnt_done++;
                if (busy && !stg_en && !done) cnt_gap++;
                pend = in_valid && in_ready;
                if (pend) begin
                    a = exp_layer * NT + exp_tok;
                    chk("bias_addr", 80'(bias_addr), 80'(a));
                    q.push_back({in_data, bias_of(a, 1), bias_of(a, 2), bias_of(a, 3), bias_of(a, 4)});
                    exp_tok++;
                    if (exp_tok == NT) begin
                        exp_tok = 0;
                        exp_layer++;
                    end
                end
            end
        end
    endtask

    task automatic start_run(input logic [2:0] cfg);
        mon_en = 1'b0;
        tick();
        mon_en = 1'b1;
        cfg_layers = cfg;
        start = 1'b1;
        tick();
        start = 1'b0;
        cfg_layers = '0;
        chk("run_started", 80'({busy, stg_en, in_ready, done}), 80'(4'b1110));
    endtask

    task automatic feed_layer(input int ntok, input int base, input bit bub, input bit end_in_feed);
        int acc = 0;
        int cyc = 0;
        logic hs;
        stg_end = end_in_feed;
        while (acc < ntok && cyc < 200) begin
            in_valid = bub ? (cyc % 2 == 0) : 1'b1;
            in_data  = W'(base + acc + 1);
            hs = in_valid && in_ready;
            tick();
            if (hs) acc++;
            cyc++;
        end
        in_valid = 1'b0;
        in_data  = '0;
        stg_end  = 1'b0;
        chk("feed_count", 80'(acc), 80'(ntok));
    endtask

    task automatic end_layer(input int n, input bit poke_start);
        chk("last_pair_ready_low", 80'({in_ready, stg_en}), 80'(2'b01));
        tick();
        if (poke_start) begin
            start = 1'b1;
            cfg_layers = 3'd3;
        end
        chk("drain_en", 80'({busy, stg_en, in_ready}), 80'(3'b110));
        tick();
        start = 1'b0;
        cfg_layers = '0;
        repeat (n) tick();
        stg_end = 1'b1;
        tick();
        stg_end = 1'b0;
        chk("next_en_low", 80'({busy, stg_en, done}), 80'(3'b100));
    endtask

    task automatic finish_run(input string tag, input int layers, input int gaps);
        tick();
        chk({tag, "_done"}, 80'({done, busy, stg_en}), 80'(3'b110));
        tick();
        chk({tag, "_idle"}, 80'({done, busy, stg_en, in_ready}), 80'(0));
        chk({tag, "_ndone"}, 80'(cnt_done), 80'(1));
        chk({tag, "_gaps"}, 80'(cnt_gap), 80'(gaps));
        chk({tag, "_fwd"}, 80'(cnt_fwd), 80'(layers * NT));
        chk({tag, "_sb_empty"}, 80'(q.size()), 80'(0));
    endtask

    initial begin
        int n;
        fork
            monitor();
        join_none

        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ctrl", 80'({busy, done, err_timeout, in_ready, stg_en, bias_addr}), 80'(0));
        chk("rst_data", {stg_data, stg_bias_1, stg_bias_2, stg_bias_3, stg_bias_4}, 80'(0));
        rst = 1'b0;

        // Single layer streaming, with a start poked during DRAIN.
        start_run(3'd1);
        feed_layer(16, 0, 1'b0, 1'b0);
        end_layer(4, 1'b1);
        finish_run("t1", 1, 1);

        // Bubbles, cfg_layers=0 runs one layer, stg_end held through FEED.
        start_run(3'd0);
        feed_layer(16, 32, 1'b1, 1'b1);
        end_layer(0, 1'b0);
        finish_run("t2", 1, 1);

        // Three layers.
        start_run(3'd3);
        for (int l = 0; l < 3; l++) begin
            feed_layer(16, 256 * l, 1'b0, 1'b0);
            end_layer(2, 1'b0);
            if (l < 2) begin
                tick();
                chk("t3_refeed", 80'({busy, stg_en, in_ready, done}), 80'(4'b1110));
            end
        end
        finish_run("t3", 3, 3);

        // Drain timeout.
        start_run(3'd1);
        feed_layer(16, 0, 1'b0, 1'b0);
        tick();
        n = 0;
        while (!done && n < DM + 20) begin
            tick();
            n++;
        end
        chk("t4_drain_cycles", 80'(n), 80'(DM));
        chk("t4_done_err", 80'({done, err_timeout, stg_en}), 80'(3'b110));
        tick();
        chk("t4_sticky", 80'({busy, err_timeout}), 80'(2'b01));
        chk("t4_gaps", 80'(cnt_gap), 80'(0));
        chk("t4_ndone", 80'(cnt_done), 80'(1));

        // err clears on the next start; reset after the 7th token.
        start_run(3'd1);
        chk("t5_err_clr", 80'(err_timeout), 80'(0));
        feed_layer(7, 0, 1'b0, 1'b0);
        mon_en = 1'b0;
        rst = 1'b1;
        #1;
        chk("t5_rst_ctrl", 80'({busy, done, err_timeout, in_ready, stg_en, bias_addr}), 80'(0));
        chk("t5_rst_data", {stg_data, stg_bias_1, stg_bias_2, stg_bias_3, stg_bias_4}, 80'(0));
        tick();
        rst = 1'b0;
        tick();
        start_run(3'd1);
        feed_layer(16, 64, 1'b0, 1'b0);
        end_layer(1, 1'b0);
        finish_run("t5", 1, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
